// File: rtl/baud_div_sequencer.sv
// Purpose: double-buffered 16-bit baud divisor with tick generator; shadow bytes commit at period boundaries.
// Latency: writes land in shadow at the write edge; commit at the next count==0 (or next cycle when disabled).
// Backpressure: none; cfg_busy flags a pending commit. Optional readback port compiled in with DIV_READBACK_EN.
module baud_div_sequencer #(
  parameter logic [15:0] LS_ADDR = 16'h002F,
  parameter logic [15:0] MS_ADDR = 16'h0030
) (
  input  logic        m_clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  input  logic        wr_en,
`ifdef DIV_READBACK_EN
  input  logic        rd_en,
  output logic [7:0]  data_out,
`endif
  output logic [15:0] divisor_active,
  output logic        baud_tick,
  output logic        cfg_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LS_PEND = 2'd1,
    ARMED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shadow_ls_q, shadow_ls_d;
  logic [7:0]  shadow_ms_q, shadow_ms_d;
  logic [15:0] div_q, div_d;
  logic [15:0] count_q, count_d;
  logic        busy_q, busy_d;

  logic ls_wr;
  logic ms_wr;
  logic any_wr;
  logic opp;
  logic commit;

  // Decode writes, find commit opportunities, and compute next state of the whole block.
  always_comb begin
    ls_wr  = wr_en && (address == LS_ADDR);
    ms_wr  = wr_en && (address == MS_ADDR);
    any_wr = ls_wr || ms_wr;
    // A disabled generator commits immediately; a running one only at a period boundary.
    opp    = (div_q == 16'd0) || (count_q == 16'd0);
    // Any register write in the commit cycle keeps the update pending so the freshest shadow wins later.
    commit = (state_q == ARMED) && opp && !any_wr;

    shadow_ls_d = ls_wr ? data_in : shadow_ls_q;
    shadow_ms_d = ms_wr ? data_in : shadow_ms_q;

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ms_wr) begin
          state_d = ARMED;
        end else if (ls_wr) begin
          state_d = LS_PEND;
        end
      end
      LS_PEND: begin
        if (ms_wr) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (commit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    div_d = commit ? {shadow_ms_q, shadow_ls_q} : div_q;

    // Reload from the divisor that will be active after this edge; zero parks the counter.
    if (opp) begin
      count_d = (div_d == 16'd0) ? 16'd0 : div_d - 16'd1;
    end else begin
      count_d = count_q - 16'd1;
    end
  end

  // Register FSM, shadow bytes, active divisor and counter; reset discards any pending update.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_ls_q <= 8'h00;
      shadow_ms_q <= 8'h00;
      div_q       <= 16'h0000;
      count_q     <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_ls_q <= shadow_ls_d;
      shadow_ms_q <= shadow_ms_d;
      div_q       <= div_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
    end
  end

  // Tick is decoded from registered state and forced low while reset is held.
  always_comb begin
    baud_tick = !reset && (div_q != 16'd0) && (count_q == 16'd0);
  end

  assign divisor_active = div_q;
  assign cfg_busy       = busy_q;

`ifdef DIV_READBACK_EN
  logic [7:0] data_q, data_d;

  // Select the addressed divisor byte on a read; unknown addresses read as zero, idle cycles hold.
  always_comb begin
    data_d = data_q;
    if (rd_en) begin
      if (address == LS_ADDR) begin
        data_d = div_q[7:0];
      end else if (address == MS_ADDR) begin
        data_d = div_q[15:8];
      end else begin
        data_d = 8'h00;
      end
    end
  end

  // Register the readback byte.
  always_ff @(posedge m_clk) begin
    if (reset) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;
`endif

endmodule

// File: tb/tb_baud_div_sequencer.sv
// Bench for baud_div_sequencer: divisor programming table, tick-time scoreboard,
// and hand sequences for mid-period update, deferred commit, reset-while-armed.
module tb_baud_div_sequencer;

  localparam logic [15:0] LS = 16'h002F;
  localparam logic [15:0] MS = 16'h0030;

  logic        m_clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic        wr_en = 1'b0;
  logic [15:0] divisor_active;
  logic        baud_tick;
  logic        cfg_busy;
`ifdef DIV_READBACK_EN
  logic        rd_en = 1'b0;
  logic [7:0]  data_out;
`endif

  baud_div_sequencer #(.LS_ADDR(16'h002F), .MS_ADDR(16'h0030)) dut (
    .m_clk          (m_clk),
    .reset          (reset),
    .address        (address),
    .data_in        (data_in),
    .wr_en          (wr_en),
`ifdef DIV_READBACK_EN
    .rd_en          (rd_en),
    .data_out       (data_out),
`endif
    .divisor_active (divisor_active),
    .baud_tick      (baud_tick),
    .cfg_busy       (cfg_busy)
  );

  always #5 m_clk = ~m_clk;

  int cyc = 0;
  always @(posedge m_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Tick scoreboard: expected tick cycles pushed by the stimulus, popped as ticks appear.
  int exp_q[$];
  int n_push = 0;
  int tick_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge m_clk) begin : mon
    int e;
    if (chk_en) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_chk++;
        $display("FAIL tick_missed: no tick seen at cycle %0d, tick required there", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (baud_tick) begin
        tick_seen++;
        e = (exp_q.size() > 0) ? exp_q[0] : -1;
        check("tick_time", cyc, e);
        if (e == cyc) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic open_win();
    exp_q.delete();
    n_push = 0;
    tick_seen = 0;
    chk_en = 1'b1;
  endtask

  task automatic push(input int t);
    exp_q.push_back(t);
    n_push++;
  endtask

  task automatic close_win();
    chk_en = 1'b0;
    check("tick_count", tick_seen, n_push);
    exp_q.delete();
  endtask

  // Drive one write during the current cycle; returns in the cycle after the write edge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    address = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("tick_during_reset", baud_tick, 1'b0);
    step();
    step();
    check("rst_div", divisor_active, 16'h0000);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_tick", baud_tick, 1'b0);
`ifdef DIV_READBACK_EN
    check("rst_data_out", data_out, 8'h00);
`endif
    reset = 1'b0;
    step();
    check("tick_after_reset", baud_tick, 1'b0);
  endtask

  typedef struct {
    bit          do_ls;
    logic [7:0]  ls;
    logic [7:0]  ms;
    logic [15:0] exp_div;
    int          period;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int e;

    vecs[0] = '{1'b1, 8'h03, 8'h00, 16'h0003, 3};
    vecs[1] = '{1'b1, 8'h01, 8'h00, 16'h0001, 1};
    vecs[2] = '{1'b0, 8'h00, 8'h01, 16'h0100, 256};
    vecs[3] = '{1'b1, 8'h05, 8'h00, 16'h0005, 5};
    vecs[4] = '{1'b1, 8'h00, 8'h00, 16'h0000, 0};

    // Programming from the disabled state: immediate commit, then regular ticks.
    foreach (vecs[i]) begin
      do_reset();
      open_win();
      if (vecs[i].do_ls) begin
        wr(LS, vecs[i].ls);
        check("busy_ls_pend", cfg_busy, 1'b1);
      end
      wr(MS, vecs[i].ms);
      check("busy_armed", cfg_busy, 1'b1);
      check("div_pre_commit", divisor_active, 16'h0000);
      step();
      c = cyc;
      check("div_commit", divisor_active, vecs[i].exp_div);
      check("busy_after_commit", cfg_busy, 1'b0);
      e = (vecs[i].period == 0) ? c + 20 : c + 3 * vecs[i].period + 2;
      if (vecs[i].period > 0)
        for (int t = c + vecs[i].period - 1; t < e; t += vecs[i].period) push(t);
      wait_to(e);
      close_win();
    end

    // Divisor 4 running, switch to 2 mid-period, then commit 0 to stop.
    do_reset();
    wr(LS, 8'h04);
    wr(MS, 8'h00);
    step();
    c = cyc;
    check("div4", divisor_active, 16'h0004);
    open_win();
    push(c + 3); push(c + 7); push(c + 11); push(c + 13);
    push(c + 15); push(c + 17); push(c + 19); push(c + 21);
    wait_to(c + 8);
    wr(LS, 8'h02);
    wr(MS, 8'h00);
    check("mid_busy_a", cfg_busy, 1'b1);
    check("mid_div_a", divisor_active, 16'h0004);
    step();
    check("mid_busy_b", cfg_busy, 1'b1);
    check("mid_div_b", divisor_active, 16'h0004);
    step();
    check("mid_div_new", divisor_active, 16'h0002);
    check("mid_busy_done", cfg_busy, 1'b0);
    wait_to(c + 18);
    wr(LS, 8'h00);
    wr(MS, 8'h00);
    step();
    check("zero_div_pending", divisor_active, 16'h0002);
    check("zero_busy_pending", cfg_busy, 1'b1);
    step();
    check("zero_div", divisor_active, 16'h0000);
    check("zero_busy", cfg_busy, 1'b0);
    wait_to(c + 40);
    close_win();

    // Divisor 2 running, MS write lands on a count==0 cycle: commit waits one period.
    do_reset();
    wr(LS, 8'h02);
    wr(MS, 8'h00);
    step();
    c = cyc;
    check("div2", divisor_active, 16'h0002);
    open_win();
    push(c + 1); push(c + 3); push(c + 5); push(c + 7);
    push(c + 12); push(c + 17); push(c + 22);
    wait_to(c + 4);
    wr(LS, 8'h05);
    wr(MS, 8'h00);
    check("defer_busy", cfg_busy, 1'b1);
    check("defer_div_a", divisor_active, 16'h0002);
    step();
    check("defer_div_b", divisor_active, 16'h0002);
    step();
    check("defer_div_new", divisor_active, 16'h0005);
    check("defer_busy_done", cfg_busy, 1'b0);
    wait_to(c + 25);
    close_win();

    // Reset while ARMED at a boundary: pending update dropped, no ticks afterwards.
    do_reset();
    wr(LS, 8'h03);
    wr(MS, 8'h00);
    step();
    c = cyc;
    open_win();
    wr(LS, 8'h07);
    wr(MS, 8'h00);
    check("armed_busy", cfg_busy, 1'b1);
    do_reset();
    check("armed_rst_div", divisor_active, 16'h0000);
    check("armed_rst_busy", cfg_busy, 1'b0);
    wait_to(c + 30);
    close_win();
    wr(16'h0031, 8'h55);
    check("busy_other_addr", cfg_busy, 1'b0);
    address = LS;
    data_in = 8'h99;
    step();
    address = 16'h0000;
    check("busy_no_wren", cfg_busy, 1'b0);
    wr(MS, 8'h00);
    check("post_rst_busy", cfg_busy, 1'b1);
    step();
    check("post_rst_div", divisor_active, 16'h0000);
    check("post_rst_busy_done", cfg_busy, 1'b0);

`ifdef DIV_READBACK_EN
    // Readback of the active divisor bytes.
    do_reset();
    wr(LS, 8'h34);
    wr(MS, 8'h12);
    step();
    check("rb_div", divisor_active, 16'h1234);
    rd_en = 1'b1;
    address = MS;
    step();
    check("rb_ms", data_out, 8'h12);
    address = 16'h0040;
    step();
    check("rb_other", data_out, 8'h00);
    address = LS;
    step();
    check("rb_ls", data_out, 8'h34);
    rd_en = 1'b0;
    address = MS;
    step();
    check("rb_hold", data_out, 8'h34);
    address = 16'h0000;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
